// File: rtl/mef_seq_ctrl.sv
// Byte-to-serial sequencer for an external 4-bit pattern detector; counts detector hits.
// Optional MEF_SEQ_CTRL_SAT_EN: hit_cnt saturates at 255 instead of wrapping.
module mef_seq_ctrl (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       in_ready,
  input  logic       cfg_we,
  input  logic [3:0] cfg_seq,
  input  logic       cnt_clr,
  output logic       det_e,
  output logic       det_clr,
  output logic [3:0] det_seq,
  input  logic       det_y,
  output logic [7:0] hit_cnt,
  output logic       hit_pulse,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t     state_reg;
  logic [7:0] byte_reg;
  logic [2:0] idx_reg;
  logic [3:0] seq_reg;
  logic [7:0] cnt_reg;
  logic       busy_reg;
  logic       done_reg;
  logic       det_clr_reg;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg   <= ST_IDLE;
      byte_reg    <= 8'h00;
      idx_reg     <= 3'd7;
      seq_reg     <= 4'b0001;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      det_clr_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // The pattern only changes between bytes, so det_seq is stable while scanning.
          if (cfg_we) seq_reg <= cfg_seq;
          if (in_valid) begin
            byte_reg    <= in_byte;
            idx_reg     <= 3'd7;
            state_reg   <= ST_SHIFT;
            busy_reg    <= 1'b1;
            det_clr_reg <= 1'b0;
          end
        end
        ST_SHIFT: begin
          idx_reg <= idx_reg - 3'd1;
          if (idx_reg == 3'd0) state_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // One extra cycle lets a match on the last bit reach det_y before det_clr.
          state_reg   <= ST_DONE;
          done_reg    <= 1'b1;
          det_clr_reg <= 1'b1;
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg   <= ST_IDLE;
          busy_reg    <= 1'b0;
          done_reg    <= 1'b0;
          det_clr_reg <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_reg <= 8'h00;
    end else if (cnt_clr) begin
      cnt_reg <= 8'h00;
    end else if (hit_pulse) begin
`ifdef MEF_SEQ_CTRL_SAT_EN
      if (cnt_reg != 8'hFF) cnt_reg <= cnt_reg + 8'd1;
`else
      cnt_reg <= cnt_reg + 8'd1;
`endif
    end
  end

  assign in_ready  = (state_reg == ST_IDLE) && clr_n;
  assign det_e     = (state_reg == ST_SHIFT) && byte_reg[idx_reg];
  assign hit_pulse = det_y && ((state_reg == ST_SHIFT) || (state_reg == ST_DRAIN));
  assign det_clr   = det_clr_reg;
  assign det_seq   = seq_reg;
  assign hit_cnt   = cnt_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_mef_seq_ctrl.sv
// Bench for mef_seq_ctrl: bit-serial detector model, cycle-offset reference model, directed byte scenarios.
module tb_mef_seq_ctrl;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       in_ready;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_seq = 4'h0;
  logic       cnt_clr = 1'b0;
  logic       det_e;
  logic       det_clr;
  logic [3:0] det_seq;
  logic       det_y = 1'b0;
  logic [7:0] hit_cnt;
  logic       hit_pulse;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;

`ifdef MEF_SEQ_CTRL_SAT_EN
  localparam logic [7:0] OVF_EXP = 8'hFF;
`else
  localparam logic [7:0] OVF_EXP = 8'h00;
`endif

  always #5 clk = ~clk;

  mef_seq_ctrl dut (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .cfg_we(cfg_we), .cfg_seq(cfg_seq), .cnt_clr(cnt_clr), .det_e(det_e), .det_clr(det_clr),
    .det_seq(det_seq), .det_y(det_y), .hit_cnt(hit_cnt), .hit_pulse(hit_pulse),
    .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // External detector: flags a completed 4-bit match one cycle after its last bit.
  logic [3:0] sh = 4'h0;
  int         nbits = 0;
  always @(posedge clk) begin
    if (det_clr) begin
      sh    <= 4'h0;
      nbits <= 0;
      det_y <= 1'b0;
    end else begin
      sh    <= {sh[2:0], det_e};
      nbits <= nbits + 1;
      det_y <= (nbits >= 3) && ({sh[2:0], det_e} == det_seq);
    end
  end

  // Reference: mk is the cycle offset since the accepting edge (0 = idle, 1..8 bits, 9 drain, 10 done).
  int         mk = 0;
  logic [7:0] mbyte = 8'h00;
  logic [7:0] mcnt = 8'h00;
  logic [3:0] mseq = 4'b0001;
  bit         m_hp;
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mk = 0; mbyte = 8'h00; mcnt = 8'h00; mseq = 4'b0001;
    end else begin
      m_hp = det_y && (mk >= 1) && (mk <= 9);
      if (cnt_clr) mcnt = 8'h00;
      else if (m_hp) begin
`ifdef MEF_SEQ_CTRL_SAT_EN
        if (mcnt != 8'hFF) mcnt = mcnt + 8'd1;
`else
        mcnt = mcnt + 8'd1;
`endif
      end
      if (mk == 0) begin
        if (cfg_we) mseq = cfg_seq;
        if (in_valid) begin mbyte = in_byte; mk = 1; end
      end else if (mk == 10) mk = 0;
      else mk = mk + 1;
    end
  end

  bit cmp_en = 1'b0;
  int done_cnt = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready", in_ready, (mk == 0) && clr_n);
      chk("busy", busy, mk != 0);
      chk("done", done, mk == 10);
      chk("det_clr", det_clr, (mk == 0) || (mk == 10));
      chk("det_e", det_e, ((mk >= 1) && (mk <= 8)) ? mbyte[8-mk] : 1'b0);
      chk("det_seq", det_seq, mseq);
      chk("hit_cnt", hit_cnt, mcnt);
      chk("hit_pulse", hit_pulse, det_y && (mk >= 1) && (mk <= 9));
      if (done) done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_byte(input logic [7:0] b, input logic we, input logic [3:0] seq,
                          input int midwe_at, input int clr_at,
                          output int lat, output logic [7:0] stream, output int hits, output int busy_n);
    for (int i = 0; i < 30 && !in_ready; i++) step();
    chk("ready_wait", in_ready, 1'b1);
    in_byte = b; in_valid = 1'b1; cfg_we = we; cfg_seq = seq;
    step();
    in_valid = 1'b0; cfg_we = 1'b0;
    lat = 0; stream = 8'h00; hits = 0; busy_n = 0;
    for (int i = 1; i <= 20; i++) begin
      cfg_we = (i == midwe_at);
      if (i == midwe_at) cfg_seq = 4'b1010;
      cnt_clr = (i == clr_at);
      @(negedge clk);
      if (i <= 8) stream[8-i] = det_e;
      if (hit_pulse) hits++;
      if (busy) busy_n++;
      if (done && lat == 0) lat = i;
      step();
      cfg_we = 1'b0; cnt_clr = 1'b0;
      if (lat != 0) break;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, hits, busy_n, c1, c2, seen, dc;
    logic [7:0] stream;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_det_e", det_e, 1'b0);
    chk("rst_det_clr", det_clr, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_hit_pulse", hit_pulse, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_hit_cnt", hit_cnt, 8'h00);
    chk("rst_det_seq", det_seq, 4'b0001);
    #1;
    clr_n = 1'b1;
    cmp_en = 1'b1;
    step();
    $display("reset released, in_ready=%0b", in_ready);

    run_byte(8'h11, 1'b0, 4'h0, 0, 0, lat, stream, hits, busy_n);
    $display("byte 0x11 seq 0001: lat=%0d stream=%02h hits=%0d hit_cnt=%0d", lat, stream, hits, hit_cnt);
    chk("b11_done_lat", lat, 10);
    chk("b11_stream", stream, 8'h11);
    chk("b11_hit_cnt", hit_cnt, 8'd2);

    run_byte(8'h70, 1'b0, 4'h0, 0, 0, lat, stream, hits, busy_n);
    $display("byte 0x70 seq 0001: busy_cycles=%0d hits=%0d hit_cnt=%0d", busy_n, hits, hit_cnt);
    chk("b70_busy_cycles", busy_n, 10);
    chk("b70_hits", hits, 0);
    chk("b70_hit_cnt", hit_cnt, 8'd2);

    run_byte(8'h70, 1'b1, 4'b0111, 3, 0, lat, stream, hits, busy_n);
    $display("byte 0x70 seq 0111 (+cfg_we while busy): hits=%0d hit_cnt=%0d det_seq=%04b", hits, hit_cnt, det_seq);
    chk("b70s7_hits", hits, 1);
    chk("b70s7_hit_cnt", hit_cnt, 8'd3);
    chk("b70s7_det_seq", det_seq, 4'b0111);

    cnt_clr = 1'b1; cfg_we = 1'b1; cfg_seq = 4'b0001;
    step();
    cnt_clr = 1'b0; cfg_we = 1'b0;
    in_byte = 8'h11; in_valid = 1'b1;
    c1 = -1; c2 = -1;
    for (int c = 0; c < 40 && c2 < 0; c++) begin
      @(negedge clk);
      seen = in_ready;
      if (seen != 0) begin
        if (c1 < 0) c1 = c; else c2 = c;
      end
      step();
    end
    in_valid = 1'b0;
    repeat (12) step();
    $display("back-to-back 0x11: transfer spacing=%0d hit_cnt=%0d", c2 - c1, hit_cnt);
    chk("b2b_spacing", c2 - c1, 11);
    chk("b2b_hit_cnt", hit_cnt, 8'd4);

    cnt_clr = 1'b1; cfg_we = 1'b1; cfg_seq = 4'b0000;
    step();
    cnt_clr = 1'b0; cfg_we = 1'b0;
    for (int n = 0; n < 51; n++) run_byte(8'h00, 1'b0, 4'h0, 0, 0, lat, stream, hits, busy_n);
    $display("preload 51 x 0x00 seq 0000: hit_cnt=%0d", hit_cnt);
    chk("preload_hit_cnt", hit_cnt, 8'hFF);
    run_byte(8'h10, 1'b1, 4'b0001, 0, 0, lat, stream, hits, busy_n);
    $display("byte 0x10 at 255: hits=%0d hit_cnt=%0d", hits, hit_cnt);
    chk("ovf_hits", hits, 1);
    chk("ovf_hit_cnt", hit_cnt, OVF_EXP);
    run_byte(8'h11, 1'b0, 4'h0, 0, 9, lat, stream, hits, busy_n);
    $display("byte 0x11 with cnt_clr on hit edge: hits=%0d hit_cnt=%0d", hits, hit_cnt);
    chk("clr_win_hits", hits, 2);
    chk("clr_win_hit_cnt", hit_cnt, 8'h00);

    run_byte(8'h11, 1'b0, 4'h0, 0, 0, lat, stream, hits, busy_n);
    chk("pre_rst_hit_cnt", hit_cnt, 8'd2);
    in_byte = 8'h11; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    dc = done_cnt;
    #1 clr_n = 1'b0;
    #1;
    $display("reset in SHIFT cycle 4: busy=%0b hit_cnt=%0d det_clr=%0b in_ready=%0b", busy, hit_cnt, det_clr, in_ready);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_hit_cnt", hit_cnt, 8'h00);
    chk("midrst_det_clr", det_clr, 1'b1);
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_det_e", det_e, 1'b0);
    repeat (2) step();
    clr_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    repeat (12) step();
    $display("after release: done pulses since reset=%0d in_ready=%0b", done_cnt - dc, in_ready);
    chk("midrst_no_done", done_cnt - dc, 0);
    chk("post_rst_idle", in_ready, 1'b1);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mef_seq_ctrl.md
MEF_SEQ_CTRL -- requirements
Module: mef_seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port clr_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port in_valid, input, 1, byte offer from the requester.
REQ-004 SHALL have port in_byte, input, 8, ASCII byte to scan.
REQ-005 SHALL have port in_ready, output, 1, byte acceptance; a transfer occurs when in_valid and in_ready are both 1 on a clk edge.
REQ-006 SHALL have port cfg_we, input, 1, pattern write strobe.
REQ-007 SHALL have port cfg_seq, input, 4, new pattern; bit 3 is the first serial bit.
REQ-008 SHALL have port cnt_clr, input, 1, synchronous clear of hit_cnt.
REQ-009 SHALL have port det_e, output, 1, serial bit driven to the detector.
REQ-010 SHALL have port det_clr, output, 1, synchronous clear driven to the detector.
REQ-011 SHALL have port det_seq, output, 4, pattern driven to the detector (the seq_r register).
REQ-012 SHALL have port det_y, input, 1, detector match flag; high in the cycle after the matching bit was clocked in.
REQ-013 SHALL have port hit_cnt, output, 8, cumulative count of matches.
REQ-014 SHALL have port hit_pulse, output, 1, combinational; equal to det_y AND (state is SHIFT or DRAIN).
REQ-015 SHALL have port busy, output, 1, high when state is not IDLE.
REQ-016 SHALL have port done, output, 1, one-cycle end-of-byte strobe.

Function
REQ-017 SHALL implement a four-state FSM: IDLE, SHIFT, DRAIN, DONE.
REQ-018 SHALL drive in_ready=1 only in IDLE with clr_n high.
REQ-019 In IDLE, on a transfer, SHALL latch in_byte into byte_r, set bit index idx=7, and go to SHIFT.
REQ-020 In SHIFT, SHALL drive det_e=byte_r[idx] and decrement idx each cycle, giving exactly 8 cycles, MSB first; SHALL go to DRAIN after idx=0.
REQ-021 DRAIN SHALL last exactly one cycle with det_e=0, then go to DONE; DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-022 Latency: transfer at edge t; SHIFT runs cycles t+1..t+8; DRAIN at t+9; DONE at t+10; in_ready=1 again at t+11.
REQ-023 SHALL drive det_clr=1 in IDLE and DONE and det_clr=0 in SHIFT and DRAIN, so the detector starts every byte from its initial state.
REQ-024 SHALL increment hit_cnt by 1 on each edge where hit_pulse=1; det_y SHALL be ignored in IDLE and DONE.
REQ-025 cnt_clr SHALL force hit_cnt to 0 on the next edge; when cnt_clr and hit_pulse occur together, cnt_clr wins (result 0).
REQ-026 hit_cnt SHALL accumulate across bytes; it SHALL NOT be cleared per byte.
REQ-027 cfg_we SHALL load cfg_seq into seq_r only in IDLE; cfg_we in any other state SHALL be ignored, so det_seq is stable for a whole byte.
REQ-028 When cfg_we and a transfer occur on the same edge in IDLE, both SHALL take effect, and the byte SHALL be scanned with the new pattern.
REQ-029 in_valid while busy SHALL be ignored (no transfer, no overrun).
REQ-030 The FSM SHALL decode unused state encodings to IDLE.

Reset
REQ-031 clr_n low SHALL, asynchronously and mid-operation included: set state to IDLE, byte_r to 0x00, idx to 7, seq_r to 4'b0001, and hit_cnt to 0.
REQ-032 During reset SHALL drive in_ready=0, det_e=0, det_clr=1, done=0, hit_pulse=0, and busy=0.
REQ-033 A byte in flight at reset SHALL be discarded, with no done pulse.

Configuration
REQ-034 Macro MEF_SEQ_CTRL_SAT_EN: when defined, hit_cnt SHALL saturate at 255 (further hits leave it at 255); when undefined, hit_cnt SHALL wrap from 255 to 0.

Verification (bench detector model: det_y high one cycle after each completed match of det_seq)
REQ-035 Reset, then offer in_byte=0x11 with seq 0001: det_e stream 0,0,0,1,0,0,0,1 -> hit_cnt=2, done at t+10.
REQ-036 Offer in_byte=0x70 ('p') with seq 0001 -> no hit_pulse, hit_cnt unchanged, busy high for 10 cycles.
REQ-037 cfg_we with cfg_seq=0111 on the same edge as a 0x70 transfer -> det_seq=0111 throughout the byte, hit_cnt +1; a cfg_we while busy -> det_seq unchanged.
REQ-038 Hold in_valid high for back-to-back bytes 0x11, 0x11 -> second transfer at t+11, hit_cnt=4.
REQ-039 Preload hit_cnt=255, then one hit -> 255 with MEF_SEQ_CTRL_SAT_EN defined, 0 without it; cnt_clr on the hit edge -> 0.
REQ-040 Drop clr_n low at SHIFT cycle 4 -> immediate IDLE, hit_cnt=0, det_clr=1, no done pulse; after release, in_ready=1.
